ula_arbiter: RTL and testbench

//  Shares one 32-bit ALU datapath (ADD/SUB/AND/OR/SLL/SRL/SRA/SLT) between NUM_REQ requesters.

---
 rtl/ula_pkg.sv | 66 ++++++
 rtl/ula_arbiter_if.sv | 35 +++
 rtl/ula_exec_core.sv | 47 ++++
 rtl/ula_arbiter.sv | 113 +++++++++++
 tb/tb_ula_arbiter.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ula_pkg.sv
// Purpose : shared ALU control codes, decode constants and helpers for the ALU arbiter slice.
// Latency : n/a (types, constants and a combinational decode function only).
// Backpressure: n/a.
package ula_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLL = 3'd4,
        ALU_SRL = 3'd5,
        ALU_SRA = 3'd6,
        ALU_SLT = 3'd7
    } alu_ctrl_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_e;

    localparam logic [1:0] AOP_ADD   = 2'd0;
    localparam logic [1:0] AOP_AND   = 2'd1;
    localparam logic [1:0] AOP_RTYPE = 2'd2;
    localparam logic [1:0] AOP_RSVD  = 2'd3;

    localparam logic [5:0] FN_SLL = 6'd0;
    localparam logic [5:0] FN_SRL = 6'd2;
    localparam logic [5:0] FN_SRA = 6'd3;
    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;
    localparam logic [5:0] FN_AND = 6'd36;
    localparam logic [5:0] FN_OR  = 6'd37;
    localparam logic [5:0] FN_SLT = 6'd42;

    // Requester index width, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // aluOp/funct -> ALU control. Anything unrecognised behaves as ADD.
    function automatic alu_ctrl_e decode_ctrl(input logic [1:0] aop, input logic [5:0] fn);
        alu_ctrl_e c;
        c = ALU_ADD;
        case (aop)
            AOP_ADD, AOP_RSVD: c = ALU_ADD;
            AOP_AND:           c = ALU_AND;
            AOP_RTYPE: begin
                case (fn)
                    FN_SLL:  c = ALU_SLL;
                    FN_SRL:  c = ALU_SRL;
                    FN_SRA:  c = ALU_SRA;
                    FN_ADD:  c = ALU_ADD;
                    FN_SUB:  c = ALU_SUB;
                    FN_AND:  c = ALU_AND;
                    FN_OR:   c = ALU_OR;
                    FN_SLT:  c = ALU_SLT;
                    default: c = ALU_ADD;
                endcase
            end
            default: c = ALU_ADD;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ula_arbiter_if.sv
// Purpose : bundle of requester-side and response-side signals of the shared ALU arbiter.
// Latency : n/a (wiring only). Ports: req_* / resp_ready driven by master, req_ready / resp_* / busy_cnt by slave.
// Backpressure: req valid/ready per requester, resp valid/ready on the single result slot.
interface ula_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 32
);
    import ula_pkg::*;
    localparam int ID_W = id_width(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_input1;
    logic [NUM_REQ*WIDTH-1:0] req_input2;
    logic [NUM_REQ*5-1:0]     req_shamt;
    logic [NUM_REQ*2-1:0]     req_aluOp;
    logic [NUM_REQ*6-1:0]     req_funct;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [ID_W-1:0]          resp_id;
    logic [WIDTH-1:0]         resp_result;
    logic                     resp_ovf;
    logic [15:0]              busy_cnt;

    modport master (
        output req_valid, req_input1, req_input2, req_shamt, req_aluOp, req_funct, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_result, resp_ovf, busy_cnt
    );

    modport slave (
        input  req_valid, req_input1, req_input2, req_shamt, req_aluOp, req_funct, resp_ready,
        output req_ready, resp_valid, resp_id, resp_result, resp_ovf, busy_cnt
    );

endinterface

// File: rtl/ula_exec_core.sv
// Purpose : combinational decode + 32-bit ALU (aluop_i, funct_i, a_i, b_i, shamt_i -> result_o, ovf_o).
// Latency : 0 cycles, purely combinational.
// Backpressure: none; the caller decides when the result is captured.
module ula_exec_core
    import ula_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       aluop_i,
    input  logic [5:0]       funct_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [4:0]       shamt_i,
    output logic [WIDTH-1:0] result_o,
    output logic             ovf_o
);
    alu_ctrl_e        ctrl;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;

    assign ctrl = decode_ctrl(aluop_i, funct_i);
    assign sum  = a_i + b_i;
    assign diff = a_i - b_i;

    always_comb begin
        result_o = sum;
        ovf_o    = 1'b0;
        case (ctrl)
            ALU_ADD: begin
                result_o = sum;
                ovf_o    = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
            end
            ALU_SUB: begin
                result_o = diff;
                ovf_o    = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
            end
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_SLL: result_o = a_i << shamt_i;
            ALU_SRL: result_o = a_i >> shamt_i;
            ALU_SRA: result_o = $unsigned($signed(a_i) >>> shamt_i);
            ALU_SLT: result_o = ($signed(a_i) < $signed(b_i)) ? WIDTH'(1) : '0;
            default: result_o = sum;
        endcase
    end

endmodule

// File: rtl/ula_arbiter.sv
// Purpose : round-robin share of one ALU between NUM_REQ requesters; ports clk, reset, bus (slave modport).
// Latency : 1 cycle from req transfer to resp_valid; 1 op/cycle while resp_ready=1.
// Backpressure: slot FULL and resp_ready=0 -> all req_ready low, response slot held stable.
module ula_arbiter
    import ula_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 32
) (
    input  logic          clk,
    input  logic          reset,
    ula_arbiter_if.slave  bus
);
    localparam int ID_W = id_width(NUM_REQ);

    slot_state_e      state_q, state_d;
    logic [ID_W-1:0]  rr_q, rr_d;
    logic [ID_W-1:0]  resp_id_q;
    logic [WIDTH-1:0] result_q;
    logic             ovf_q;
    logic [15:0]      cnt_q;

    logic             gnt_vld;
    logic [ID_W-1:0]  gnt_id;
    logic             grant;
    logic [NUM_REQ-1:0] ready;
    logic [WIDTH-1:0] op_a, op_b;
    logic [4:0]       op_sh;
    logic [1:0]       op_aop;
    logic [5:0]       op_fn;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;

    // First valid requester at or after the rr pointer, wrapping modulo NUM_REQ.
    always_comb begin
        int idx;
        gnt_vld = 1'b0;
        gnt_id  = '0;
        idx     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!gnt_vld && bus.req_valid[idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = ID_W'(idx);
            end
        end
    end

    // Operand select for the winning requester.
    always_comb begin
        int sel;
        sel    = int'(gnt_id);
        op_a   = bus.req_input1[sel*WIDTH +: WIDTH];
        op_b   = bus.req_input2[sel*WIDTH +: WIDTH];
        op_sh  = bus.req_shamt[sel*5 +: 5];
        op_aop = bus.req_aluOp[sel*2 +: 2];
        op_fn  = bus.req_funct[sel*6 +: 6];
    end

    ula_exec_core #(.WIDTH(WIDTH)) u_core (
        .aluop_i  (op_aop),
        .funct_i  (op_fn),
        .a_i      (op_a),
        .b_i      (op_b),
        .shamt_i  (op_sh),
        .result_o (alu_res),
        .ovf_o    (alu_ovf)
    );

    // Slot FSM: a drain in the same cycle frees the slot for a new grant.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        ready   = '0;
        grant   = gnt_vld && !reset && ((state_q == ST_EMPTY) || bus.resp_ready);
        if (grant) begin
            ready[gnt_id] = 1'b1;
            state_d       = ST_FULL;
            rr_d          = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
        end else if ((state_q == ST_FULL) && bus.resp_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_EMPTY;
            rr_q      <= '0;
            resp_id_q <= '0;
            result_q  <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            if (grant) begin
                resp_id_q <= gnt_id;
                result_q  <= alu_res;
                ovf_q     <= alu_ovf;
                if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign bus.req_ready   = ready;
    assign bus.resp_valid  = (state_q == ST_FULL);
    assign bus.resp_id     = resp_id_q;
    assign bus.resp_result = result_q;
    assign bus.resp_ovf    = ovf_q;
    assign bus.busy_cnt    = cnt_q;

endmodule

// File: tb/tb_ula_arbiter.sv
// Purpose : self-checking bench for ula_arbiter (directed corner cases + randomized traffic vs. reference model).
// Latency : model expects results one cycle after each transfer.
// Backpressure: resp_ready toggled to exercise FULL hold and drain+reload.
module tb_ula_arbiter;
    localparam int NR = 3;
    localparam int W  = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ula_arbiter_if #(.NUM_REQ(NR), .WIDTH(W)) bus ();
    ula_arbiter #(.NUM_REQ(NR), .WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Requester-side pending ops (held until accepted).
    logic        p_vld [NR];
    logic [1:0]  p_aop [NR];
    logic [5:0]  p_fn  [NR];
    logic [31:0] p_a   [NR];
    logic [31:0] p_b   [NR];
    logic [4:0]  p_sh  [NR];
    logic        rdy_in;

    // Reference model state.
    bit          m_vld;
    int          m_id;
    logic [31:0] m_res;
    bit          m_ovf;
    int          m_rr;
    int          m_cnt;
    bit          m_clean;

    typedef struct {
        logic [1:0]  aop;
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] r;
        bit          o;
    } vec_t;
    vec_t vecs[$];

    task automatic addv(input logic [1:0] aop, input logic [5:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input logic [31:0] r, input bit o);
        vec_t v;
        v.aop = aop; v.fn = fn; v.a = a; v.b = b; v.sh = sh; v.r = r; v.o = o;
        vecs.push_back(v);
    endtask

    // Behavioural ALU: overflow judged by whether the exact signed result fits in 32 bits.
    function automatic void ref_alu(input logic [1:0] aop, input logic [5:0] fn, input logic [31:0] a,
                                    input logic [31:0] b, input logic [4:0] sh,
                                    output logic [31:0] r, output bit o);
        longint sa, sb, s;
        int kind;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        o  = 1'b0;
        kind = 0;
        if (aop == 2'd1) kind = 2;
        else if (aop == 2'd2) begin
            case (fn)
                6'd0:  kind = 4;
                6'd2:  kind = 5;
                6'd3:  kind = 6;
                6'd34: kind = 1;
                6'd36: kind = 2;
                6'd37: kind = 3;
                6'd42: kind = 7;
                default: kind = 0;
            endcase
        end
        case (kind)
            0: begin s = sa + sb; r = s[31:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            1: begin s = sa - sb; r = s[31:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            2: r = a & b;
            3: r = a | b;
            4: r = a << sh;
            5: r = a >> sh;
            6: r = $unsigned($signed(a) >>> sh);
            default: r = (sa < sb) ? 32'd1 : 32'd0;
        endcase
    endfunction

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            bus.req_valid[i]          = p_vld[i];
            bus.req_input1[i*W +: W]  = p_a[i];
            bus.req_input2[i*W +: W]  = p_b[i];
            bus.req_shamt[i*5 +: 5]   = p_sh[i];
            bus.req_aluOp[i*2 +: 2]   = p_aop[i];
            bus.req_funct[i*6 +: 6]   = p_fn[i];
        end
        bus.resp_ready = rdy_in;
    endtask

    task automatic set_op(input int i, input logic [1:0] aop, input logic [5:0] fn,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        p_vld[i] = 1'b1; p_aop[i] = aop; p_fn[i] = fn; p_a[i] = a; p_b[i] = b; p_sh[i] = sh;
    endtask

    task automatic clear_ops();
        for (int i = 0; i < NR; i++) p_vld[i] = 1'b0;
    endtask

    task automatic model_reset();
        m_vld = 0; m_id = 0; m_res = '0; m_ovf = 0; m_rr = 0; m_cnt = 0; m_clean = 1;
    endtask

    // One clock: drive, check against model at negedge, advance model at posedge.
    task automatic step(input bit rst);
        int g;
        logic [NR-1:0] exp_rdy;
        reset = rst;
        drive();
        @(negedge clk);
        check_eq("resp_valid", bus.resp_valid, m_vld);
        if (m_vld || m_clean) begin
            check_eq("resp_id", bus.resp_id, m_id);
            check_eq("resp_result", bus.resp_result, m_res);
            check_eq("resp_ovf", bus.resp_ovf, m_ovf);
        end
        check_eq("busy_cnt", bus.busy_cnt, m_cnt);
        g = -1;
        if (!rst && (!m_vld || rdy_in)) begin
            for (int i = 0; i < NR; i++) begin
                int idx;
                idx = (m_rr + i) % NR;
                if (g < 0 && p_vld[idx]) g = idx;
            end
        end
        exp_rdy = (g >= 0) ? NR'(1 << g) : '0;
        check_eq("req_ready", bus.req_ready, exp_rdy);
        @(posedge clk);
        if (rst) model_reset();
        else if (g >= 0) begin
            ref_alu(p_aop[g], p_fn[g], p_a[g], p_b[g], p_sh[g], m_res, m_ovf);
            m_vld = 1; m_id = g; m_rr = (g + 1) % NR; m_clean = 0;
            if (m_cnt < 65535) m_cnt++;
            p_vld[g] = 1'b0;
        end else if (m_vld && rdy_in) m_vld = 0;
        #1;
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h7FFFFFFF;
            2: return 32'h80000000;
            3: return 32'hFFFFFFFF;
            4: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [5:0] rnd_fn();
        logic [5:0] tbl [8];
        tbl[0] = 6'd0; tbl[1] = 6'd2; tbl[2] = 6'd3; tbl[3] = 6'd32;
        tbl[4] = 6'd34; tbl[5] = 6'd36; tbl[6] = 6'd37; tbl[7] = 6'd42;
        if ($urandom_range(0, 7) == 0) return 6'($urandom);
        return tbl[$urandom_range(0, 7)];
    endfunction

    initial begin
        for (int i = 0; i < NR; i++) begin
            p_vld[i] = 0; p_aop[i] = '0; p_fn[i] = '0; p_a[i] = '0; p_b[i] = '0; p_sh[i] = '0;
        end
        rdy_in = 1'b1;
        reset  = 1'b1;
        drive();
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_eq("rst_valid", bus.resp_valid, 0);
        check_eq("rst_id", bus.resp_id, 0);
        check_eq("rst_result", bus.resp_result, 0);
        check_eq("rst_ovf", bus.resp_ovf, 0);
        check_eq("rst_busy", bus.busy_cnt, 0);
        set_op(0, 2'd0, 6'd0, 32'd1, 32'd1, 5'd0);
        drive();
        #1;
        check_eq("rst_ready_low", bus.req_ready, 0);
        clear_ops();
        step(1'b1);

        // ADD 5+7 on requester 0
        set_op(0, 2'd0, 6'd0, 32'd5, 32'd7, 5'd0);
        step(1'b0);
        check_eq("t1_valid", bus.resp_valid, 1);
        check_eq("t1_id", bus.resp_id, 0);
        check_eq("t1_result", bus.resp_result, 12);
        check_eq("t1_ovf", bus.resp_ovf, 0);
        step(1'b0);

        // Two requesters always valid -> 0,1,0,1
        step(1'b1);
        for (int c = 0; c < 4; c++) begin
            if (!p_vld[0]) set_op(0, 2'd0, 6'd0, $urandom, $urandom, 5'd0);
            if (!p_vld[1]) set_op(1, 2'd1, 6'd0, $urandom, $urandom, 5'd0);
            step(1'b0);
            check_eq("t2_id", bus.resp_id, c % 2);
        end
        check_eq("t2_busy", bus.busy_cnt, 4);
        clear_ops();
        step(1'b0);

        // Directed ALU corner cases, rotated across requesters
        addv(2'd0, 6'd0,  32'h7FFFFFFF, 32'h1,        5'd0,  32'h80000000, 1);
        addv(2'd2, 6'd34, 32'h80000000, 32'h1,        5'd0,  32'h7FFFFFFF, 1);
        addv(2'd2, 6'd3,  32'hF0000000, 32'h0,        5'd4,  32'hFF000000, 0);
        addv(2'd2, 6'd2,  32'hF0000000, 32'h0,        5'd4,  32'h0F000000, 0);
        addv(2'd2, 6'd42, 32'hFFFFFFFF, 32'h1,        5'd0,  32'h1,        0);
        addv(2'd2, 6'd42, 32'h1,        32'hFFFFFFFF, 5'd0,  32'h0,        0);
        addv(2'd2, 6'd0,  32'h1,        32'h0,        5'd31, 32'h80000000, 0);
        addv(2'd1, 6'd0,  32'hF0F0,     32'hFF00,     5'd0,  32'hF000,     0);
        addv(2'd2, 6'd37, 32'hF0F0,     32'hFF00,     5'd0,  32'hFFF0,     0);
        addv(2'd2, 6'd36, 32'hF0F0,     32'hFF00,     5'd0,  32'hF000,     0);
        addv(2'd2, 6'd5,  32'h7FFFFFFF, 32'h7FFFFFFF, 5'd0,  32'hFFFFFFFE, 1);
        addv(2'd3, 6'd34, 32'h80000000, 32'h80000000, 5'd0,  32'h0,        1);
        addv(2'd2, 6'd34, 32'd5,        32'd7,        5'd0,  32'hFFFFFFFE, 0);
        addv(2'd2, 6'd3,  32'h12345678, 32'h0,        5'd0,  32'h12345678, 0);
        foreach (vecs[k]) begin
            set_op(k % NR, vecs[k].aop, vecs[k].fn, vecs[k].a, vecs[k].b, vecs[k].sh);
            step(1'b0);
            check_eq("vec_result", bus.resp_result, vecs[k].r);
            check_eq("vec_ovf", bus.resp_ovf, vecs[k].o);
        end
        step(1'b0);

        // Backpressure: hold FULL slot for 3 cycles, then drain+grant together
        rdy_in = 1'b0;
        set_op(0, 2'd0, 6'd0, 32'd10, 32'd20, 5'd0);
        step(1'b0);
        set_op(1, 2'd0, 6'd0, 32'd1, 32'd1, 5'd0);
        for (int c = 0; c < 3; c++) begin
            step(1'b0);
            check_eq("t5_hold_ready", bus.req_ready, 0);
            check_eq("t5_hold_id", bus.resp_id, 0);
            check_eq("t5_hold_res", bus.resp_result, 30);
        end
        rdy_in = 1'b1;
        step(1'b0);
        check_eq("t5_reload_valid", bus.resp_valid, 1);
        check_eq("t5_reload_id", bus.resp_id, 1);
        check_eq("t5_reload_res", bus.resp_result, 2);

        // Reset with FULL slot and two valid requesters; rr must return to 0
        step(1'b0);
        set_op(0, 2'd0, 6'd0, 32'd3, 32'd4, 5'd0);
        step(1'b0);
        rdy_in = 1'b0;
        set_op(0, 2'd0, 6'd0, 32'd100, 32'd1, 5'd0);
        set_op(1, 2'd0, 6'd0, 32'd200, 32'd1, 5'd0);
        step(1'b1);
        check_eq("t6_valid", bus.resp_valid, 0);
        check_eq("t6_busy", bus.busy_cnt, 0);
        check_eq("t6_result", bus.resp_result, 0);
        rdy_in = 1'b1;
        step(1'b0);
        check_eq("t6_rr_id", bus.resp_id, 0);
        check_eq("t6_rr_res", bus.resp_result, 101);

        // Randomized traffic with random backpressure and occasional reset
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!p_vld[i] && $urandom_range(0, 1) == 1)
                    set_op(i, 2'($urandom_range(0, 3)), rnd_fn(), rnd_val(), rnd_val(), 5'($urandom));
            end
            rdy_in = ($urandom_range(0, 3) != 0);
            step($urandom_range(0, 199) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
